ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 126 ++++++++++++
 tb/tb_ifu_fetch.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one word-aligned fetch at a time, buffers the
// returned instruction for the decoder, and squashes stale work on redirects.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_addr_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_data_i,
    input  logic        resp_err_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        fault_o,
    input  logic [31:0] pred_pc_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;

    logic        req_fire;
    logic [31:0] redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc_i & ~32'h3;
    assign req_fire            = req_valid_o & req_ready_i;

    assign req_valid_o = (state_q == S_REQ);
    assign req_addr_o  = pc_q;
    // A redirect squashes the held pair in the same cycle so the decoder never takes it.
    assign valid_o     = (state_q == S_HOLD) & ~redirect_valid_i;
    assign inst_o      = inst_q;
    assign pc_o        = pc_q;
    assign fault_o     = (state_q == S_HOLD) & err_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        inst_d  = inst_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_aligned;
                end
            end
            S_REQ: begin
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_aligned;
                    // The request already left for the old PC; its response must be dropped.
                    if (req_fire) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_aligned;
                    if (resp_valid_i) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (resp_valid_i) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d  = resp_err_i ? NOP_INST : resp_data_i;
                        err_d   = resp_err_i;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid_i) begin
                    pc_d    = redirect_pc_aligned;
                    state_d = S_REQ;
                end else if (ready_i) begin
                    pc_d    = pred_pc_i;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            inst_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus a randomized run
// checked against a transaction-level model of the expected instruction stream.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid_o, req_ready_i;
    logic [31:0] req_addr_o;
    logic        resp_valid_i, resp_err_i;
    logic [31:0] resp_data_i;
    logic        valid_o, ready_i, fault_o;
    logic [31:0] inst_o, pc_o, pred_pc_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;

    int checks = 0;
    int failures = 0;

    // Memory model state and knobs
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          mem_lat;
    bit          mem_rand, mem_fixed_en, err_hash, pred_rand;
    logic [31:0] mem_fixed, err_addr;

    ifu_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clock(clock), .reset(reset),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i), .resp_err_i(resp_err_i),
        .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o), .pc_o(pc_o), .fault_o(fault_o),
        .pred_pc_i(pred_pc_i), .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return mem_fixed_en ? mem_fixed : {a[15:0] ^ 16'hA5C3, a[31:16]};
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a == err_addr) || (err_hash && a[5:2] == 4'hB);
    endfunction

    // Called during the low clock phase with inputs settled: captures a fire,
    // passes the rising edge, then drives the memory response for the new cycle.
    task automatic cycle();
        logic [31:0] r;
        if (!reset && req_valid_o && req_ready_i) begin
            mem_pend = 1;
            mem_addr = req_addr_o;
            mem_cnt  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
        end
        @(negedge clock);
        resp_valid_i = 0;
        resp_err_i   = 0;
        resp_data_i  = 32'h0BAD_F00D;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                resp_valid_i = 1;
                resp_err_i   = mem_err(mem_addr);
                resp_data_i  = resp_err_i ? 32'hBAD0_0BAD : mem_data(mem_addr);
                mem_pend     = 0;
            end else begin
                mem_cnt--;
            end
        end
        r = $urandom;
        if (pred_rand && $urandom_range(0, 7) == 0)
            pred_pc_i = r[0] ? 32'hFFFF_FFFC : (r & 32'hFFFF_FFFC);
        else
            pred_pc_i = pc_o + 32'd4;
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            #1;
            if (valid_o) begin ok = 1; break; end
            cycle();
        end
    endtask

    task automatic wait_fire(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            #1;
            if (req_valid_o && req_ready_i) begin ok = 1; break; end
            cycle();
        end
    endtask

    task automatic do_reset();
        reset = 1;
        ready_i = 1; req_ready_i = 1; redirect_valid_i = 0; redirect_pc_i = 0;
        resp_valid_i = 0; resp_err_i = 0; resp_data_i = 0;
        mem_pend = 0; mem_lat = 0; mem_rand = 0; mem_fixed_en = 0; mem_fixed = 0;
        err_hash = 0; err_addr = 32'h1; pred_rand = 0;
        pred_pc_i = RESET_PC + 32'd4;
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        ready_i = 1; req_ready_i = 1; redirect_valid_i = 0; redirect_pc_i = 0;
        resp_valid_i = 0; resp_err_i = 0; resp_data_i = 0;
        mem_pend = 0; mem_lat = 0; mem_rand = 0; mem_fixed_en = 1; mem_fixed = 32'h0000_0093;
        err_hash = 0; err_addr = 32'h1; pred_rand = 0;
        pred_pc_i = RESET_PC + 32'd4;
        #1;
        checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", req_valid_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
        checks++; if (fault_o !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b exp=0", fault_o); end
        checks++; if (inst_o !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst_o); end
        checks++; if (pc_o !== RESET_PC) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc_o, RESET_PC); end
        checks++; if (req_addr_o !== RESET_PC) begin failures++; $display("FAIL rst_req_addr got=%h exp=%h", req_addr_o, RESET_PC); end
        @(negedge clock);
        reset = 0;
        // A stray response while idle must be ignored.
        resp_valid_i = 1; resp_data_i = 32'hCAFE_F00D; resp_err_i = 1;
    endtask

    task automatic test_first_fetch();
        int n_x = 0, first_req = -1, first_valid = -1;
        int cyc[2];
        logic [31:0] pcs[2], insts[2];
        for (int n = 0; n < 16; n++) begin
            #1;
            if (req_valid_o && first_req < 0) first_req = n;
            if (valid_o && first_valid < 0) first_valid = n;
            if (valid_o && ready_i && n_x < 2) begin
                cyc[n_x] = n; pcs[n_x] = pc_o; insts[n_x] = inst_o; n_x++;
                $display("xfer pc=%h inst=%h fault=%b", pc_o, inst_o, fault_o);
            end
            cycle();
        end
        checks++; if (first_req !== 1) begin failures++; $display("FAIL first_req_cycle got=%0d exp=1", first_req); end
        checks++; if (first_valid !== 3) begin failures++; $display("FAIL first_valid_cycle got=%0d exp=3", first_valid); end
        checks++; if (n_x !== 2) begin failures++; $display("FAIL first_xfer_count got=%0d exp=2", n_x); end
        if (n_x == 2) begin
            checks++; if (pcs[0] !== RESET_PC) begin failures++; $display("FAIL first_pc0 got=%h exp=%h", pcs[0], RESET_PC); end
            checks++; if (insts[0] !== 32'h0000_0093) begin failures++; $display("FAIL first_inst0 got=%h exp=00000093", insts[0]); end
            checks++; if (pcs[1] !== RESET_PC + 32'd4) begin failures++; $display("FAIL first_pc1 got=%h exp=%h", pcs[1], RESET_PC + 32'd4); end
            checks++; if (cyc[1] - cyc[0] !== 3) begin failures++; $display("FAIL first_gap got=%0d exp=3", cyc[1] - cyc[0]); end
        end
    endtask

    task automatic test_hold_stall();
        bit ok;
        logic [31:0] s_pc, s_inst;
        do_reset();
        ready_i = 0;
        wait_valid(20, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL hold_reach got=%b exp=1", ok); end
        s_pc = pc_o; s_inst = inst_o;
        checks++; if (s_pc !== RESET_PC) begin failures++; $display("FAIL hold_pc got=%h exp=%h", s_pc, RESET_PC); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (valid_o !== 1'b1 || pc_o !== s_pc || inst_o !== s_inst) begin
                failures++; $display("FAIL hold_stable[%0d] got=%b/%h/%h exp=1/%h/%h", k, valid_o, pc_o, inst_o, s_pc, s_inst);
            end
            cycle(); #1;
        end
        ready_i = 1; #1;
        checks++; if (valid_o !== 1'b1 || pc_o !== s_pc) begin failures++; $display("FAIL hold_6th got=%b/%h exp=1/%h", valid_o, pc_o, s_pc); end
        $display("xfer pc=%h inst=%h fault=%b", pc_o, inst_o, fault_o);
        cycle(); #1;
        checks++; if (valid_o !== 1'b0 || req_valid_o !== 1'b1 || req_addr_o !== s_pc + 32'd4) begin
            failures++; $display("FAIL hold_after got=%b/%b/%h exp=0/1/%h", valid_o, req_valid_o, req_addr_o, s_pc + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok, got_fire = 0, saw_valid = 0;
        logic [31:0] fire_addr = 0;
        do_reset();
        mem_lat = 2; mem_fixed_en = 1; mem_fixed = 32'hDEAD_BEEF;
        wait_fire(10, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rw_first_fire got=%b exp=1", ok); end
        cycle();
        redirect_valid_i = 1; redirect_pc_i = 32'h8000_0103;
        #1;
        cycle();
        redirect_valid_i = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (valid_o) saw_valid = 1;
            if (req_valid_o && req_ready_i) begin got_fire = 1; fire_addr = req_addr_o; end
            cycle();
            if (got_fire) break;
        end
        mem_fixed_en = 0;
        checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL rw_dropped got=%b exp=0", saw_valid); end
        checks++; if (got_fire !== 1'b1 || fire_addr !== 32'h8000_0100) begin
            failures++; $display("FAIL rw_next_addr got=%b/%h exp=1/80000100", got_fire, fire_addr);
        end
        wait_valid(20, ok);
        checks++; if (ok !== 1'b1 || pc_o !== 32'h8000_0100 || inst_o !== mem_data(32'h8000_0100)) begin
            failures++; $display("FAIL rw_deliver got=%b/%h/%h exp=1/80000100/%h", ok, pc_o, inst_o, mem_data(32'h8000_0100));
        end
        cycle();
    endtask

    task automatic test_redirect_hold();
        bit ok;
        do_reset();
        ready_i = 0;
        wait_valid(20, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rh_reach got=%b exp=1", ok); end
        ready_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h8000_0200;
        #1;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rh_valid_forced got=%b exp=0", valid_o); end
        cycle();
        redirect_valid_i = 0;
        #1;
        checks++; if (valid_o !== 1'b0 || req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_0200) begin
            failures++; $display("FAIL rh_next_req got=%b/%b/%h exp=0/1/80000200", valid_o, req_valid_o, req_addr_o);
        end
        wait_valid(20, ok);
        checks++; if (ok !== 1'b1 || pc_o !== 32'h8000_0200) begin failures++; $display("FAIL rh_deliver got=%b/%h exp=1/80000200", ok, pc_o); end
        cycle();
    endtask

    task automatic test_err();
        int n_x = 0;
        logic [31:0] pcs[3], insts[3];
        logic        flt[3];
        do_reset();
        err_addr = 32'h8000_0008;
        for (int i = 0; i < 40 && n_x < 3; i++) begin
            #1;
            if (valid_o && ready_i) begin
                pcs[n_x] = pc_o; insts[n_x] = inst_o; flt[n_x] = fault_o; n_x++;
                $display("xfer pc=%h inst=%h fault=%b", pc_o, inst_o, fault_o);
            end
            cycle();
        end
        checks++; if (n_x !== 3) begin failures++; $display("FAIL err_count got=%0d exp=3", n_x); end
        if (n_x == 3) begin
            checks++; if (flt[0] !== 1'b0 || insts[0] !== mem_data(RESET_PC)) begin
                failures++; $display("FAIL err_clean got=%b/%h exp=0/%h", flt[0], insts[0], mem_data(RESET_PC));
            end
            checks++; if (pcs[2] !== 32'h8000_0008 || insts[2] !== NOP_INST || flt[2] !== 1'b1) begin
                failures++; $display("FAIL err_fault got=%h/%h/%b exp=80000008/%h/1", pcs[2], insts[2], flt[2], NOP_INST);
            end
        end
    endtask

    task automatic test_req_stall_reset();
        bit ok;
        do_reset();
        req_ready_i = 0;
        cycle();
        redirect_valid_i = 1; redirect_pc_i = 32'h8000_0300;
        #1;
        checks++; if (req_valid_o !== 1'b1 || req_addr_o !== RESET_PC) begin
            failures++; $display("FAIL rs_redirect_cycle got=%b/%h exp=1/%h", req_valid_o, req_addr_o, RESET_PC);
        end
        cycle();
        redirect_valid_i = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h8000_0300) begin
                failures++; $display("FAIL rs_stall[%0d] got=%b/%h exp=1/80000300", k, req_valid_o, req_addr_o);
            end
            cycle();
        end
        #1; reset = 1; #1;
        checks++; if (req_valid_o !== 1'b0 || valid_o !== 1'b0 || fault_o !== 1'b0 || inst_o !== 32'h0
                      || req_addr_o !== RESET_PC || pc_o !== RESET_PC) begin
            failures++; $display("FAIL rs_async_reset got=%b/%b/%b/%h/%h/%h exp=0/0/0/0/%h/%h",
                                 req_valid_o, valid_o, fault_o, inst_o, req_addr_o, pc_o, RESET_PC, RESET_PC);
        end
        // Reset in WAIT: the late response arrives while idle and must not be used.
        @(negedge clock);
        reset = 0; req_ready_i = 1; mem_lat = 1; mem_fixed_en = 1; mem_fixed = 32'hDEAD_0042;
        wait_fire(10, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rs_fire got=%b exp=1", ok); end
        cycle();
        #2; reset = 1; #1;
        checks++; if (req_valid_o !== 1'b0 || valid_o !== 1'b0) begin
            failures++; $display("FAIL rs_wait_reset got=%b/%b exp=0/0", req_valid_o, valid_o);
        end
        cycle();
        reset = 0;
        mem_fixed_en = 0;
        wait_valid(20, ok);
        checks++; if (ok !== 1'b1 || pc_o !== RESET_PC || inst_o !== mem_data(RESET_PC)) begin
            failures++; $display("FAIL rs_late_resp got=%b/%h/%h exp=1/%h/%h", ok, pc_o, inst_o, RESET_PC, mem_data(RESET_PC));
        end
        cycle();
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = RESET_PC;
        bit          hold_pend = 0, rq_pend = 0;
        logic [31:0] h_pc, h_inst, rq_addr;
        logic        h_fault;
        logic [31:0] exp_inst;
        logic        exp_fault;
        int          idle = 0;
        do_reset();
        mem_rand = 1; err_hash = 1; pred_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            ready_i          = ($urandom_range(0, 3) != 0);
            req_ready_i      = ($urandom_range(0, 9) >= 3);
            redirect_valid_i = ($urandom_range(0, 19) == 0);
            redirect_pc_i    = $urandom;
            #1;
            if (redirect_valid_i) begin
                checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rnd_redirect_valid got=%b exp=0", valid_o); end
            end
            if (hold_pend) begin
                checks++; if (valid_o !== !redirect_valid_i || pc_o !== h_pc || inst_o !== h_inst || fault_o !== h_fault) begin
                    failures++; $display("FAIL rnd_hold_stable got=%b/%h/%h/%b exp=%b/%h/%h/%b",
                                         valid_o, pc_o, inst_o, fault_o, !redirect_valid_i, h_pc, h_inst, h_fault);
                end
            end
            if (rq_pend) begin
                checks++; if (req_valid_o !== 1'b1 || req_addr_o !== rq_addr) begin
                    failures++; $display("FAIL rnd_req_stable got=%b/%h exp=1/%h", req_valid_o, req_addr_o, rq_addr);
                end
            end
            hold_pend = valid_o && !ready_i && !redirect_valid_i;
            h_pc = pc_o; h_inst = inst_o; h_fault = fault_o;
            rq_pend = req_valid_o && !req_ready_i && !redirect_valid_i;
            rq_addr = req_addr_o;
            if (req_valid_o && req_ready_i) begin
                checks++; if (mem_pend !== 1'b0) begin failures++; $display("FAIL rnd_outstanding got=%b exp=0", mem_pend); end
                if (!redirect_valid_i) begin
                    checks++; if (req_addr_o !== exp_pc) begin failures++; $display("FAIL rnd_req_addr got=%h exp=%h", req_addr_o, exp_pc); end
                end
            end
            if (valid_o && ready_i && !redirect_valid_i) begin
                exp_fault = mem_err(exp_pc);
                exp_inst  = exp_fault ? NOP_INST : mem_data(exp_pc);
                checks++; if (pc_o !== exp_pc || inst_o !== exp_inst || fault_o !== exp_fault) begin
                    failures++; $display("FAIL rnd_xfer got=%h/%h/%b exp=%h/%h/%b", pc_o, inst_o, fault_o, exp_pc, exp_inst, exp_fault);
                end
                $display("xfer pc=%h inst=%h fault=%b", pc_o, inst_o, fault_o);
                exp_pc = pred_pc_i;
                idle = 0;
            end
            if (redirect_valid_i) exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
            idle++;
            if (idle > 200) begin
                checks++; failures++;
                $display("FAIL rnd_progress got=no transfer in %0d cycles exp=transfer", idle);
                break;
            end
            cycle();
        end
        redirect_valid_i = 0;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_err();
        test_req_stall_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
